// File: rtl/axi_irq_ctrl.sv
// axi_irq_ctrl: AXI4-Lite interrupt controller with enable/edge-select, fixed priority and claim/complete sequencing.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer ahead of source sampling for asynchronous sources.
module axi_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int NUM_SRC_p     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  input  logic [31:0]              i_axi_wdata,
  input  logic                     i_axi_wvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  input  logic                     i_axi_rready,
  output logic                     o_axi_awready,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic [NUM_SRC_p-1:0]     i_src,
  output logic                     o_irq
);
  logic [NUM_SRC_p-1:0] src_in, s_src_q, src_prev, pending, enable, edge_sel;
  logic [NUM_SRC_p-1:0] active, rise, cand_oh, claim_clr, sel_chg, pending_nxt;
  logic [4:0] cand_id, is_id;
  logic cand_vld, in_service, wr_en, rd_en, claim, wr_err, rd_err, unused_addr;
  logic [2:0] wa, ra;
  logic [31:0] rd_data;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC_p-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_src;
      sync2 <= sync1;
    end
  end
  assign src_in = sync2;
`else
  assign src_in = i_src;
`endif

  assign unused_addr   = ^{i_axi_awaddr, i_axi_araddr};
  assign wa            = i_axi_awaddr[4:2];
  assign ra            = i_axi_araddr[4:2];
  assign wr_en         = i_axi_awvalid && i_axi_wvalid && !o_axi_bvalid;
  assign rd_en         = i_axi_arvalid && !o_axi_rvalid;
  assign o_axi_awready = wr_en;
  assign o_axi_wready  = wr_en;
  assign o_axi_arready = rd_en;
  assign active        = pending & enable;
  assign rise          = s_src_q & ~src_prev;

  // scan high to low so the lowest active index is the one left standing
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    cand_oh  = '0;
    for (int i = NUM_SRC_p - 1; i >= 0; i--) begin
      if (active[i]) begin
        cand_vld   = 1'b1;
        cand_id    = 5'(i + 1);
        cand_oh    = '0;
        cand_oh[i] = 1'b1;
      end
    end
  end

  assign claim     = rd_en && ra == 3'd3 && !in_service && cand_vld;
  assign claim_clr = claim ? cand_oh & edge_sel : '0;
  assign sel_chg   = (wr_en && wa == 3'd2) ? edge_sel ^ i_axi_wdata[NUM_SRC_p-1:0] : '0;
  // a fresh edge beats the claim clear; an edge-select change clears outright
  assign pending_nxt = ((edge_sel & ((pending & ~claim_clr) | rise)) | (~edge_sel & s_src_q)) & ~sel_chg;
  assign wr_err    = !(wa == 3'd1 || wa == 3'd2 || wa == 3'd4);
  assign rd_err    = ra > 3'd3;

  always_comb
    rd_data = ra == 3'd0 ? 32'(pending) :
              ra == 3'd1 ? 32'(enable) :
              ra == 3'd2 ? 32'(edge_sel) :
              ra == 3'd3 ? {27'd0, in_service ? is_id : cand_id} : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_src_q      <= '0;
      src_prev     <= '0;
      pending      <= '0;
      enable       <= '0;
      edge_sel     <= '0;
      in_service   <= 1'b0;
      is_id        <= '0;
      o_irq        <= 1'b0;
      o_axi_bvalid <= 1'b0;
      o_axi_bresp  <= 2'b00;
      o_axi_rvalid <= 1'b0;
      o_axi_rdata  <= '0;
      o_axi_rresp  <= 2'b00;
    end else begin
      s_src_q  <= src_in;
      src_prev <= s_src_q;
      pending  <= pending_nxt;
      o_irq    <= cand_vld && !in_service;
      if (wr_en) begin
        o_axi_bvalid <= 1'b1;
        o_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
        if (wa == 3'd1) enable <= i_axi_wdata[NUM_SRC_p-1:0];
        if (wa == 3'd2) edge_sel <= i_axi_wdata[NUM_SRC_p-1:0];
      end else if (i_axi_bready) begin
        o_axi_bvalid <= 1'b0;
      end
      if (rd_en) begin
        o_axi_rvalid <= 1'b1;
        o_axi_rdata  <= rd_data;
        o_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (i_axi_rready) begin
        o_axi_rvalid <= 1'b0;
      end
      if (claim) begin
        in_service <= 1'b1;
        is_id      <= cand_id;
      end else if (wr_en && wa == 3'd4 && i_axi_wdata == {27'd0, is_id}) begin
        in_service <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_irq_ctrl.sv
// tb_axi_irq_ctrl: directed scenarios plus randomized source/claim/complete traffic against a register-level model.
module tb_axi_irq_ctrl;
  localparam int N  = 8;
  localparam int AW = 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata, rdata;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0] bresp, rresp;
  logic [N-1:0] src;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  axi_irq_ctrl #(.AXI_ADDR_BW_p(AW), .NUM_SRC_p(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .i_axi_wdata(wdata), .i_axi_wvalid(wvalid),
    .i_axi_bready(bready), .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .i_axi_rready(rready),
    .o_axi_awready(awready), .o_axi_wready(wready), .o_axi_bresp(bresp), .o_axi_bvalid(bvalid),
    .o_axi_arready(arready), .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid),
    .i_src(src), .o_irq(irq)
  );

  task automatic do_reset;
    rst_n = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; src = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, output logic [1:0] r);
    int k;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1; bready = 1;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bvalid) break;
    end
    awvalid = 0; wvalid = 0;
    if (k == 20) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout addr=%h got bvalid=0 exp bvalid=1", a);
      r = 2'b11;
    end else r = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
    int k;
    araddr = a; arvalid = 1; rready = 1;
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (rvalid) break;
    end
    arvalid = 0;
    if (k == 20) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout addr=%h got rvalid=0 exp rvalid=1", a);
      d = 32'hDEAD_BEEF; r = 2'b11;
    end else begin
      d = rdata; r = rresp;
    end
    @(posedge clk); #1;
    rready = 0;
  endtask

  function automatic logic [4:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 5'(i + 1);
    return 5'd0;
  endfunction

  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    do_reset();
    n_cmp++; if ({irq, bvalid, rvalid, awready, wready, arready} !== 6'd0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=000000", {irq, bvalid, rvalid, awready, wready, arready}); end
    n_cmp++; if ({rdata, bresp, rresp} !== 36'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {rdata, bresp, rresp}); end
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd0 || r !== 2'b00) begin n_err++; $display("FAIL reset_claim got=%h/%b exp=0/00", d, r); end
    // write response left hanging, then reset: nothing must come out afterwards
    awaddr = 12'h04; wdata = 32'hFF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    n_cmp++; if (bvalid !== 1'b1) begin n_err++; $display("FAIL abort_pre got=%b exp=1", bvalid); end
    rst_n = 0; #2;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL abort_async got=%b exp=0", bvalid); end
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL abort_post got=%b exp=0", bvalid); end
    axi_read(12'h04, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL abort_enable got=%h exp=0", d); end
  endtask

  task automatic test_regs;
    logic [31:0] d; logic [1:0] r;
    axi_write(12'h04, 32'h0C, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL wr_enable_resp got=%b exp=00", r); end
    axi_write(12'h08, 32'h08, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL wr_edge_resp got=%b exp=00", r); end
    axi_read(12'h04, d, r);
    n_cmp++; if (d !== 32'h0C || r !== 2'b00) begin n_err++; $display("FAIL rd_enable got=%h/%b exp=c/00", d, r); end
    axi_read(12'h08, d, r);
    n_cmp++; if (d !== 32'h08 || r !== 2'b00) begin n_err++; $display("FAIL rd_edge got=%h/%b exp=8/00", d, r); end
    axi_read(12'h14, d, r);
    n_cmp++; if (d !== 32'd0 || r !== 2'b10) begin n_err++; $display("FAIL rd_unmapped got=%h/%b exp=0/10", d, r); end
    axi_read(12'h10, d, r);
    n_cmp++; if (d !== 32'd0 || r !== 2'b10) begin n_err++; $display("FAIL rd_complete got=%h/%b exp=0/10", d, r); end
    axi_write(12'h1C, 32'hFF, r);
    n_cmp++; if (r !== 2'b10) begin n_err++; $display("FAIL wr_unmapped got=%b exp=10", r); end
    axi_write(12'h0C, 32'h1, r);
    n_cmp++; if (r !== 2'b10) begin n_err++; $display("FAIL wr_claim got=%b exp=10", r); end
    axi_read(12'h04, d, r);
    n_cmp++; if (d !== 32'h0C) begin n_err++; $display("FAIL enable_kept got=%h exp=c", d); end
  endtask

  task automatic test_edge;
    logic [31:0] d; logic [1:0] r;
    src[3] = 1;
    @(posedge clk); #1 src[3] = 0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_n0 got=%b exp=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_n1 got=%b exp=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_n2 got=%b exp=1", irq); end
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd4 || r !== 2'b00) begin n_err++; $display("FAIL edge_claim got=%h/%b exp=4/00", d, r); end
    axi_read(12'h00, d, r);
    n_cmp++; if (d[3] !== 1'b0) begin n_err++; $display("FAIL edge_pend_clr got=%b exp=0", d[3]); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_srv got=%b exp=0", irq); end
    axi_write(12'h10, 32'd4, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0 || r !== 2'b00) begin n_err++; $display("FAIL edge_complete got=%b/%b exp=0/00", irq, r); end
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL edge_idle_claim got=%h exp=0", d); end
  endtask

  task automatic test_priority;
    logic [31:0] d; logic [1:0] r;
    src[2] = 1; src[3] = 1;
    @(posedge clk); #1 src[3] = 0;
    repeat (3) @(posedge clk); #1;
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL prio_first got=%h exp=3", d); end
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL prio_repeat got=%h exp=3", d); end
    axi_write(12'h10, 32'd5, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0 || r !== 2'b00) begin n_err++; $display("FAIL wrong_complete got=%b/%b exp=0/00", irq, r); end
    axi_write(12'h10, 32'd3, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL prio_return got=%b exp=1", irq); end
    src[2] = 0;
    repeat (4) @(posedge clk); #1;
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL prio_second got=%h exp=4", d); end
    src[2] = 1;
    axi_write(12'h10, 32'd4, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL level_reraise got=%b exp=1", irq); end
    axi_read(12'h0C, d, r);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL prio_third got=%h exp=3", d); end
    src[2] = 0;
    axi_write(12'h10, 32'd3, r);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prio_idle got=%b exp=0", irq); end
  endtask

  task automatic test_set_wins;
    logic [31:0] d; logic [1:0] r;
    src[3] = 1;
    @(posedge clk); #1 src[3] = 0;
    repeat (3) @(posedge clk); #1;
    src[3] = 1;
    @(posedge clk); #1 src[3] = 0; araddr = 12'h0C; arvalid = 1; rready = 1;
    @(posedge clk); #1 arvalid = 0;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'd4) begin n_err++; $display("FAIL setwin_claim got=%b/%h exp=1/4", rvalid, rdata); end
    @(posedge clk); #1 rready = 0;
    axi_read(12'h00, d, r);
    n_cmp++; if (d[3] !== 1'b1) begin n_err++; $display("FAIL setwin_pend got=%b exp=1", d[3]); end
    axi_write(12'h10, 32'd4, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL setwin_irq got=%b exp=1", irq); end
    axi_read(12'h0C, d, r);
    axi_write(12'h10, 32'd4, r);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (d !== 32'd4 || irq !== 1'b0) begin n_err++; $display("FAIL setwin_final got=%h/%b exp=4/0", d, irq); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] held;
    awaddr = 12'h00; wdata = 32'hFF; awvalid = 1; bready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({awready, wready, bvalid} !== 3'b000) begin n_err++; $display("FAIL aw_wait%0d got=%b exp=000", i, {awready, wready, bvalid}); end
    end
    wvalid = 1;
    #1;
    n_cmp++; if ({awready, wready} !== 2'b11) begin n_err++; $display("FAIL aw_w_pulse got=%b exp=11", {awready, wready}); end
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    held = bresp;
    n_cmp++; if (bvalid !== 1'b1 || held !== 2'b10) begin n_err++; $display("FAIL ro_write got=%b/%b exp=1/10", bvalid, held); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bvalid !== 1'b1 || bresp !== held || awready !== 1'b0) begin n_err++; $display("FAIL bhold%0d got=%b/%b exp=1/%b", i, bvalid, bresp, held); end
    end
    bready = 1;
    @(posedge clk); #1 bready = 0;
    n_cmp++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL b_release got=%b exp=0", bvalid); end
  endtask

  task automatic test_random;
    logic [31:0] d; logic [1:0] r;
    logic [N-1:0] m_en, m_es, m_pend, cur, nv, ne, nes;
    logic m_is; logic [4:0] m_id, exp_c;
    logic [31:0] cv;
    do_reset();
    m_en = '0; m_es = '0; m_pend = '0; cur = '0; m_is = 0; m_id = '0;
    for (int it = 0; it < 60; it++) begin
      nv = N'($urandom);
      m_pend = (m_es & (m_pend | (nv & ~cur))) | (~m_es & nv);
      cur = nv; src = nv;
      repeat (4) @(posedge clk); #1;
      axi_read(12'h00, d, r);
      n_cmp++; if (d !== 32'(m_pend) || r !== 2'b00) begin n_err++; $display("FAIL rnd_pend it=%0d got=%h/%b exp=%h/00", it, d, r, m_pend); end
      n_cmp++; if (irq !== ((|(m_pend & m_en)) && !m_is)) begin n_err++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, irq, (|(m_pend & m_en)) && !m_is); end
      case ($urandom_range(0, 2))
        0: begin
          exp_c = m_is ? m_id : lowest(m_pend & m_en);
          axi_read(12'h0C, d, r);
          n_cmp++; if (d !== 32'(exp_c)) begin n_err++; $display("FAIL rnd_claim it=%0d got=%h exp=%h", it, d, exp_c); end
          if (!m_is && exp_c != 0) begin
            m_is = 1; m_id = exp_c;
            if (m_es[exp_c-1]) m_pend[exp_c-1] = 1'b0;
          end
        end
        1: begin
          cv = $urandom_range(0, 1) ? 32'(m_id) : 32'($urandom_range(0, 9));
          axi_write(12'h10, cv, r);
          n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL rnd_complete it=%0d got=%b exp=00", it, r); end
          if (m_is && cv == 32'(m_id)) m_is = 0;
        end
        default: begin
          ne = N'($urandom); nes = N'($urandom);
          axi_write(12'h04, 32'(ne), r);
          axi_write(12'h08, 32'(nes), r);
          m_pend = m_pend & ~(m_es ^ nes);
          m_en = ne; m_es = nes;
          m_pend = (m_es & m_pend) | (~m_es & cur);
        end
      endcase
      repeat (3) @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge();
    test_priority();
    test_set_wins();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_irq_ctrl.md
Name: axi_irq_ctrl

Overview:
- AXI4-Lite slave interrupt controller placed between SoC peripheral IRQ outputs (UART, timer, future blocks) and one PicoRV32 `irq` bit.
- Latches level- or edge-type sources and masks them with an enable register.
- Arbitrates by fixed priority, where the lowest index wins.
- Sequences service through claim/complete registers, with one source in service at a time.

Parameters:
- AXI_ADDR_BW_p, 12, AXI address width; only bits [4:2] are decoded.
- NUM_SRC_p, 8, number of interrupt sources (1..31).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_axi_awaddr  input  AXI_ADDR_BW_p  write address
- i_axi_awvalid  input  1  write address valid
- i_axi_wdata  input  32  write data
- i_axi_wvalid  input  1  write data valid
- i_axi_bready  input  1  write response ready
- i_axi_araddr  input  AXI_ADDR_BW_p  read address
- i_axi_arvalid  input  1  read address valid
- i_axi_rready  input  1  read data ready
- o_axi_awready  output  1  write address accepted
- o_axi_wready  output  1  write data accepted
- o_axi_bresp  output  2  write response
- o_axi_bvalid  output  1  write response valid
- o_axi_arready  output  1  read address accepted
- o_axi_rdata  output  32  read data
- o_axi_rresp  output  2  read response
- o_axi_rvalid  output  1  read data valid
- i_src  input  NUM_SRC_p  raw interrupt sources, active high
- o_irq  output  1  registered interrupt request to CPU

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0; ENABLE, EDGE_SEL, PENDING = 0; in-service flag = 0; in-service id = 0.
- Register map, byte offsets:
  - 0x00 PENDING (RO)
  - 0x04 ENABLE (RW)
  - 0x08 EDGE_SEL (RW; 1 = rising-edge source, 0 = level source)
  - 0x0C CLAIM (RO)
  - 0x10 COMPLETE (WO)
  - Bits above NUM_SRC_p-1 read as 0.
- Unmapped offsets: writes are ignored and return SLVERR (2'b10); reads return 0 with SLVERR. Writes to RO registers and reads of COMPLETE return SLVERR with no side effect.
- Write handshake:
  - o_axi_awready and o_axi_wready pulse together for one cycle when awvalid && wvalid && !bvalid.
  - The register update and bvalid=1 occur on the same edge.
  - bvalid holds until bready.
  - A lone AW or W waits; no skid buffer.
- Read handshake:
  - o_axi_arready pulses one cycle when arvalid && !rvalid.
  - rdata/rvalid are registered on the next edge and held until rready.
  - A read and a write may complete in the same cycle.
- Source sampling: i_src is registered once into s_src_q.
  - Edge source: PENDING[i] is set when s_src_q[i] is 1 and its previous value was 0.
  - Level source: PENDING[i] equals s_src_q[i].
- Arbitration: candidate = lowest i with PENDING[i] & ENABLE[i].
- o_irq registered = (candidate exists) && !in_service. Source sampled high at edge N gives PENDING at N+1 and o_irq at N+2.
- CLAIM read side effects:
  - Not in service, candidate exists: returns i+1; sets in_service and the in-service id; clears PENDING[i] if it is an edge source.
  - Not in service, no candidate: returns 0.
  - In service: returns the current in-service id, no side effects.
- COMPLETE write: data equal to the in-service id clears in_service. Any other value is ignored, still with OKAY.
- A level source still high after complete re-raises o_irq two cycles later.
- Simultaneous new edge and claim clear on the same source: set wins, so pending stays 1.
- Clearing an ENABLE bit: pending is retained but not signalled. A later EDGE_SEL change clears that bit's pending.
- Reset asserted mid-transaction aborts it; no response is issued after reset release.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN.
- Defined: i_src passes through a 2-flop synchronizer before s_src_q, for asynchronous sources. o_irq latency becomes N+4.
- Undefined: single sampling register only, latency N+2. Sources must be synchronous to clk.

Test Plan:
- Reset → write ENABLE=0x0C, EDGE_SEL=0x08 → read back 0x0C/0x08 OKAY; read 0x14 → SLVERR, rdata 0.
- Pulse i_src[3] one cycle (edge, enabled) → o_irq=1 two cycles after sampling; CLAIM=4; PENDING bit3=0; o_irq=0; COMPLETE=4 → in-service cleared, o_irq stays 0.
- Hold i_src[2] (level) and pulse i_src[3] together → CLAIM=3 → COMPLETE=3 → o_irq returns → CLAIM=4 (src2 released first), then CLAIM=3 again if src2 still high after COMPLETE=4.
- CLAIM while in service → same id returned twice; COMPLETE=5 while in-service id=3 → OKAY, o_irq remains 0.
- Edge on src3 in the same cycle as its CLAIM clear → PENDING[3] stays 1; after COMPLETE=4, o_irq re-asserts.
- AW asserted 3 cycles before W → awready/wready both pulse only in the cycle W arrives; bready held low 5 cycles → bvalid holds with stable bresp.
